// File: rtl/pdp8i_timing_gen.sv
// PDP-8/I central timing generator.
// Sequences the major time states TS1..TS4, emits a time pulse TPn during the
// last TP_WIDTH clocks of each state, and handles run/stop, single-step and
// the I/O pause that stretches TS2. Outputs are active-high; the downstream
// power-amplifier stage inverts and buffers them onto the backplane.
module pdp8i_timing_gen #(
    parameter int TS_LEN   = 10,
    parameter int TP_WIDTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic key_start,
    input  logic key_stop,
    input  logic single_step,
    input  logic io_pause,
    output logic run,
    output logic ts1,
    output logic ts2,
    output logic ts3,
    output logic ts4,
    output logic tp1,
    output logic tp2,
    output logic tp3,
    output logic tp4,
    output logic cycle_end
);

    localparam int CW = (TS_LEN > 1) ? $clog2(TS_LEN) : 1;

    // Last count of a time state, first count with the pulse high, and the
    // count at which an I/O pause freezes TS2 just before TP2 would start.
    localparam logic [CW-1:0] CNT_LAST = CW'(TS_LEN - 1);
    localparam logic [CW-1:0] CNT_TP   = CW'(TS_LEN - TP_WIDTH);
    localparam logic [CW-1:0] CNT_HOLD = CW'(TS_LEN - TP_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TS1  = 3'd1,
        TS2  = 3'd2,
        TS3  = 3'd3,
        TS4  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            stop_pending_q, stop_pending_d;

    // Next-state logic: start from idle, count through each time state, and
    // decide at the end of TS4 whether to loop into TS1 or halt.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_d          = run_q;
        stop_pending_d = stop_pending_q;

        case (state_q)
            IDLE: begin
                if (key_start && !key_stop) begin
                    state_d = TS1;
                    cnt_d   = '0;
                    run_d   = 1'b1;
                end
            end

            default: begin
                if (key_stop) begin
                    stop_pending_d = 1'b1;
                end

                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        TS1:     state_d = TS2;
                        TS2:     state_d = TS3;
                        TS3:     state_d = TS4;
                        default: begin
                            if (stop_pending_q || key_stop || single_step) begin
                                state_d        = IDLE;
                                run_d          = 1'b0;
                                stop_pending_d = 1'b0;
                            end else begin
                                state_d = TS1;
                            end
                        end
                    endcase
                end else if (state_q == TS2 && cnt_q == CNT_HOLD && io_pause) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State, phase counter, run flip-flop and pending-stop flag; reset drops
    // everything to idle without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            run_q          <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_q          <= run_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Outputs are pure decodes of registers so no input can glitch them.
    assign run       = run_q;
    assign ts1       = (state_q == TS1);
    assign ts2       = (state_q == TS2);
    assign ts3       = (state_q == TS3);
    assign ts4       = (state_q == TS4);
    assign tp1       = ts1 && (cnt_q >= CNT_TP);
    assign tp2       = ts2 && (cnt_q >= CNT_TP);
    assign tp3       = ts3 && (cnt_q >= CNT_TP);
    assign tp4       = ts4 && (cnt_q >= CNT_TP);
    assign cycle_end = ts4 && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_pdp8i_timing_gen.sv
// Directed testbench for the PDP-8/I timing generator (TS_LEN=10, TP_WIDTH=2).
// Inputs change just after each falling edge; outputs are compared on the
// falling edge, half a clock away from the active rising edge.
module tb_pdp8i_timing_gen;

    logic clk;
    logic reset;
    logic key_start;
    logic key_stop;
    logic single_step;
    logic io_pause;
    logic run;
    logic ts1, ts2, ts3, ts4;
    logic tp1, tp2, tp3, tp4;
    logic cycle_end;

    logic [9:0] obs;

    int checkCount;
    int errorCount;
    int ceTotal;
    int ceBefore;

    pdp8i_timing_gen #(
        .TS_LEN   (10),
        .TP_WIDTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_start   (key_start),
        .key_stop    (key_stop),
        .single_step (single_step),
        .io_pause    (io_pause),
        .run         (run),
        .ts1         (ts1),
        .ts2         (ts2),
        .ts3         (ts3),
        .ts4         (ts4),
        .tp1         (tp1),
        .tp2         (tp2),
        .tp3         (tp3),
        .tp4         (tp4),
        .cycle_end   (cycle_end)
    );

    assign obs = {run, ts1, ts2, ts3, ts4, tp1, tp2, tp3, tp4, cycle_end};

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Running tally of cycle_end pulses seen on falling edges.
    initial ceTotal = 0;
    always @(negedge clk) begin
        if (cycle_end === 1'b1) ceTotal = ceTotal + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected {run,ts1..ts4,tp1..tp4,cycle_end} at clock k (1-based) of a
    // running cycle whose TS2 is stretched by s clocks. Each pulse covers the
    // last two clocks of its state; cycle_end the very last clock of TS4.
    function automatic logic [9:0] expVec(input int k, input int s);
        int   ts;
        int   p;
        int   len;
        logic tp;
        logic ce;
        len = 10;
        if (k <= 10) begin
            ts = 1; p = k - 1;
        end else if (k <= 20 + s) begin
            ts = 2; p = k - 11; len = 10 + s;
        end else if (k <= 30 + s) begin
            ts = 3; p = k - 21 - s;
        end else begin
            ts = 4; p = k - 31 - s;
        end
        tp = (p >= len - 2);
        ce = (ts == 4) && (p == len - 1);
        return {1'b1, ts == 1, ts == 2, ts == 3, ts == 4,
                tp && ts == 1, tp && ts == 2, tp && ts == 3, tp && ts == 4, ce};
    endfunction

    // Walks one full cycle clock by clock. Caller has already raised
    // key_start (or the previous cycle loops back). s>0 holds io_pause for s
    // clocks starting at TS2 cnt=7; ts3Pause also waves io_pause during TS3;
    // stopK pulses key_stop in that clock of the cycle (0 = never).
    task automatic applyStimulus(input string tag, input int s, input bit ts3Pause,
                                 input int stopK);
        for (int k = 1; k <= 40 + s; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s k=%0d", tag, k), obs, expVec(k, s));
            key_start = 1'b0;
            key_stop  = (k == stopK);
            io_pause  = (s > 0 && k >= 18 && k < 18 + s) ||
                        (ts3Pause && k >= 24 + s && k <= 29 + s);
        end
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b1;
        key_start   = 1'b0;
        key_stop    = 1'b0;
        single_step = 1'b0;
        io_pause    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("resetState", obs, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idleAfterReset", obs, 0);

        // Basic run: two back-to-back cycles, stop requested during TS2 of the second.
        key_start = 1'b1;
        applyStimulus("cycle1", 0, 1'b0, 0);
        applyStimulus("cycle2Stop", 0, 1'b0, 15);
        @(negedge clk);
        checkOutput("stopIdle", obs, 0);
        repeat (4) @(negedge clk);
        checkOutput("stayIdle", obs, 0);

        // Start and stop together in idle: stop wins.
        key_start = 1'b1;
        key_stop  = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        key_stop  = 1'b0;
        checkOutput("startStopSame", obs, 0);
        @(negedge clk);
        checkOutput("startStopSame2", obs, 0);

        // Stretched TS2, ignored pause in TS3, stop in the very last clock.
        key_start = 1'b1;
        applyStimulus("pause", 5, 1'b1, 45);
        @(negedge clk);
        key_stop = 1'b0;
        io_pause = 1'b0;
        checkOutput("finalClockStop", obs, 0);

        // Single-step: each start yields exactly one cycle.
        ceBefore    = ceTotal;
        single_step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_start = 1'b1;
            applyStimulus($sformatf("step%0d", i), 0, 1'b0, 0);
            @(negedge clk);
            checkOutput($sformatf("stepIdle%0d", i), obs, 0);
            repeat (19) @(negedge clk);
            checkOutput($sformatf("stepGap%0d", i), obs, 0);
        end
        checkOutput("stepCycleEnds", ceTotal - ceBefore, 3);
        single_step = 1'b0;

        // Asynchronous reset in TS3 while tp3 is high.
        key_start = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            key_start = 1'b0;
            checkOutput($sformatf("preReset k=%0d", k), obs, expVec(k, 0));
        end
        #2 reset = 1'b1;
        #1 checkOutput("asyncReset", obs, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("postResetIdle %0d", k), obs, 0);
        end

        // Fresh start after reset, halted at the end by a stop in the final clock.
        key_start = 1'b1;
        applyStimulus("restart", 0, 1'b0, 40);
        @(negedge clk);
        key_stop = 1'b0;
        checkOutput("restartIdle", obs, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
